// File: rtl/bram_dma_pkg.sv
// Shared constants for the block-RAM DMA engine: FSM state encodings,
// mode/direction codes and default bus widths.
package bram_dma_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/bram_dma_addr_gen.sv
// Loadable up/down address counter; nxt_o is the value the counter takes at
// the next clock edge, so the engine can register it straight onto the RAM bus.
module bram_dma_addr_gen
    import bram_dma_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              dir_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] nxt_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Next count: load wins over step; stepping wraps modulo 2**ADDR_W.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (step_i && (dir_i == DIR_UP)) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end else if (step_i && (dir_i == DIR_DOWN)) begin
            cnt_d = cnt_q - ADDR_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {ADDR_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nxt_o = cnt_d;

endmodule

// File: rtl/bram_dma_engine.sv
// Byte copy/fill bus master driving one block-RAM port.
// Optional build macro BRAM_DMA_CHECKSUM_EN adds csum, the modulo-256 sum of bytes written.
module bram_dma_engine
    import bram_dma_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic              dir,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] remaining,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef BRAM_DMA_CHECKSUM_EN
   ,output logic [DATA_W-1:0] csum
`endif
);

    logic [1:0]        state_q, state_d;
    logic              mode_q, dir_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              aborted_q, aborted_d;
    logic              busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic              accept_s, src_step_s, dst_step_s;
    logic [ADDR_W-1:0] src_nxt_s, dst_nxt_s;

    assign accept_s = (state_q == S_IDLE) && start;

    bram_dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clk(clk), .rst_n(rst_n), .load_i(accept_s), .step_i(src_step_s),
        .dir_i(dir_q), .load_val_i(src_addr), .nxt_o(src_nxt_s)
    );

    bram_dma_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
        .clk(clk), .rst_n(rst_n), .load_i(accept_s), .step_i(dst_step_s),
        .dir_i(dir_q), .load_val_i(dst_addr), .nxt_o(dst_nxt_s)
    );

    // Transfer FSM; an abort lets the access of the current cycle finish.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        aborted_d  = aborted_q;
        src_step_s = 1'b0;
        dst_step_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d     = len;
                    aborted_d = 1'b0;
                    if (len == {ADDR_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else if (mode == MODE_COPY) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                dst_step_s = 1'b1;
                src_step_s = (mode_q == MODE_COPY);
                rem_d      = rem_q - ADDR_W'(1);
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (rem_d == {ADDR_W{1'b0}}) begin
                    state_d = S_DONE;
                end else if (mode_q == MODE_COPY) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_WR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode for the coming state; the RAM address holds while idle.
    always_comb begin
        busy_d = (state_d == S_RD) || (state_d == S_WR);
        done_d = (state_d == S_DONE);
        we_d   = (state_d == S_WR);
        case (state_d)
            S_RD:    addr_d = src_nxt_s;
            S_WR:    addr_d = dst_nxt_s;
            default: addr_d = addr_q;
        endcase
    end

    // State, count and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_q     <= {ADDR_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            mode_q    <= 1'b0;
            dir_q     <= 1'b0;
            fill_q    <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            if (accept_s) begin
                mode_q <= mode;
                dir_q  <= dir;
                fill_q <= fill_val;
            end
        end
    end

    // Copy data passes straight from the read port to keep 2 cycles per byte.
    assign mem_wdata = we_q ? ((mode_q == MODE_FILL) ? fill_q : mem_rdata) : {DATA_W{1'b0}};
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign remaining = rem_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;

`ifdef BRAM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Running sum of every byte committed to RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            csum_q <= {DATA_W{1'b0}};
        end else if (we_q) begin
            csum_q <= csum_q + mem_wdata;
        end
    end

    assign csum = csum_q;
`else
`endif

endmodule

// File: tb/tb_bram_dma_engine.sv
// Directed bench for bram_dma_engine with a 64KB behavioural RAM (1-cycle read latency).
module tb_bram_dma_engine;
    import bram_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] src_addr = 16'h0000;
    logic [15:0] dst_addr = 16'h0000;
    logic [15:0] len = 16'h0000;
    logic [7:0]  fill_val = 8'h00;
    logic        busy, done, aborted, mem_we;
    logic [15:0] remaining, mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
`ifdef BRAM_DMA_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'h0000;
    logic [7:0]  bd_data = 8'h00;
    logic [7:0]  ram [0:65535];

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [15:0] ra_q[$];

    int n_checks = 0;
    int n_fail = 0;

    bram_dma_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .dir(dir),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .aborted(aborted), .remaining(remaining),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef BRAM_DMA_CHECKSUM_EN
       ,.csum(csum)
`endif
    );

    always #5 clk = ~clk;

    // RAM model with a backdoor preload port, plus a log of bus writes and reads.
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end else if (busy) begin
            ra_q.push_back(mem_addr);
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_start(input logic m, input logic d, input logic [15:0] s,
                            input logic [15:0] ds, input logic [15:0] l, input logic [7:0] f);
        @(negedge clk);
        mode = m; dir = d; src_addr = s; dst_addr = ds; len = l; fill_val = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output bit ok);
        nbusy = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, aborted, mem_we} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, aborted, mem_we});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, remaining} !== 40'h0) begin
            n_fail++; $display("FAIL reset_buses: addr %h wdata %h rem %h expected all 0", mem_addr, mem_wdata, remaining);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        int nb; bit ok; int base;
        base = wa_q.size();
        do_start(MODE_FILL, DIR_UP, 16'h0000, 16'h1000, 16'd4, 8'hA5);
        wait_done(nb, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fill_done_timeout: got no done expected done"); end
        n_checks++;
        if (nb !== 4) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d expected 4", nb); end
        n_checks++;
        if (wa_q.size() - base !== 4) begin
            n_fail++; $display("FAIL fill_write_count: got %0d expected 4", wa_q.size() - base);
        end
        for (int i = 0; i < 4 && base + i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[base+i] !== 16'h1000 + 16'(i) || wd_q[base+i] !== 8'hA5) begin
                n_fail++; $display("FAIL fill_write%0d: got %h<=%h expected %h<=a5", i, wa_q[base+i], wd_q[base+i], 16'h1000 + 16'(i));
            end
        end
        n_checks++;
        if ({busy, aborted, remaining} !== 18'h0 || mem_addr !== 16'h1003) begin
            n_fail++; $display("FAIL fill_done_state: busy %b ab %b rem %h addr %h expected 0 0 0000 1003", busy, aborted, remaining, mem_addr);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h1003) begin
            n_fail++; $display("FAIL fill_done_pulse: done %b we %b addr %h expected 0 0 1003", done, mem_we, mem_addr);
        end
    endtask

    task automatic test_copy_up();
        int nb; bit ok; int base;
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) preload(16'h2000 + 16'(i), exp_d[i]);
        base = wa_q.size();
        do_start(MODE_COPY, DIR_UP, 16'h2000, 16'h3000, 16'd3, 8'h00);
        wait_done(nb, ok);
        n_checks++;
        if (!ok || nb !== 6) begin n_fail++; $display("FAIL copy_up_busy: got ok=%b busy=%0d expected ok=1 busy=6", ok, nb); end
        n_checks++;
        if (wa_q.size() - base !== 3) begin
            n_fail++; $display("FAIL copy_up_write_count: got %0d expected 3", wa_q.size() - base);
        end
        for (int i = 0; i < 3 && base + i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[base+i] !== 16'h3000 + 16'(i) || wd_q[base+i] !== exp_d[i]) begin
                n_fail++; $display("FAIL copy_up_write%0d: got %h<=%h expected %h<=%h", i, wa_q[base+i], wd_q[base+i], 16'h3000 + 16'(i), exp_d[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({ram[16'h3000], ram[16'h3001], ram[16'h3002]} !== 24'h112233) begin
            n_fail++; $display("FAIL copy_up_ram: got %h%h%h expected 112233", ram[16'h3000], ram[16'h3001], ram[16'h3002]);
        end
    endtask

    task automatic test_copy_down_wrap();
        int nb; bit ok; int wbase; int rbase;
        logic [15:0] exp_ra [3] = '{16'h0001, 16'h0000, 16'hFFFF};
        logic [15:0] exp_wa [3] = '{16'h8001, 16'h8000, 16'h7FFF};
        logic [7:0]  exp_d  [3] = '{8'hA1, 8'hA0, 8'hAF};
        for (int i = 0; i < 3; i++) preload(exp_ra[i], exp_d[i]);
        wbase = wa_q.size();
        rbase = ra_q.size();
        do_start(MODE_COPY, DIR_DOWN, 16'h0001, 16'h8001, 16'd3, 8'h00);
        wait_done(nb, ok);
        n_checks++;
        if (!ok || nb !== 6) begin n_fail++; $display("FAIL copy_down_busy: got ok=%b busy=%0d expected ok=1 busy=6", ok, nb); end
        n_checks++;
        if (ra_q.size() - rbase !== 3 || wa_q.size() - wbase !== 3) begin
            n_fail++; $display("FAIL copy_down_counts: got rd=%0d wr=%0d expected 3 3", ra_q.size() - rbase, wa_q.size() - wbase);
        end
        for (int i = 0; i < 3 && rbase + i < ra_q.size() && wbase + i < wa_q.size(); i++) begin
            n_checks++;
            if (ra_q[rbase+i] !== exp_ra[i] || wa_q[wbase+i] !== exp_wa[i] || wd_q[wbase+i] !== exp_d[i]) begin
                n_fail++; $display("FAIL copy_down_step%0d: got rd %h wr %h<=%h expected rd %h wr %h<=%h",
                                   i, ra_q[rbase+i], wa_q[wbase+i], wd_q[wbase+i], exp_ra[i], exp_wa[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_abort();
        int base;
        base = wa_q.size();
        do_start(MODE_FILL, DIR_UP, 16'h0000, 16'h4000, 16'd10, 8'h5A);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b1 || aborted !== 1'b1 || busy !== 1'b0 || remaining !== 16'd7) begin
            n_fail++; $display("FAIL abort_done: done %b ab %b busy %b rem %0d expected 1 1 0 7", done, aborted, busy, remaining);
        end
        n_checks++;
        if (wa_q.size() - base !== 3) begin
            n_fail++; $display("FAIL abort_write_count: got %0d expected 3", wa_q.size() - base);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || aborted !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL abort_after: done %b ab %b we %b expected 0 1 0", done, aborted, mem_we);
        end
    endtask

    task automatic test_len_zero_and_busy_start();
        int nb; bit ok; int base;
        base = wa_q.size();
        do_start(MODE_FILL, DIR_UP, 16'h0000, 16'h4800, 16'd0, 8'hEE);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || aborted !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL len0_done: done %b busy %b ab %b we %b expected 1 0 0 0", done, busy, aborted, mem_we);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || wa_q.size() !== base) begin
            n_fail++; $display("FAIL len0_after: done %b writes %0d expected 0 0", done, wa_q.size() - base);
        end
        do_start(MODE_FILL, DIR_UP, 16'h0000, 16'h5000, 16'd5, 8'h3C);
        mode = MODE_COPY; len = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (remaining !== 16'd4 || busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_start_ignored: rem %0d busy %b expected 4 1", remaining, busy);
        end
        wait_done(nb, ok);
        n_checks++;
        if (!ok || nb !== 4 || wa_q.size() - base !== 5) begin
            n_fail++; $display("FAIL busy_start_run: ok %b busy %0d writes %0d expected 1 4 5", ok, nb, wa_q.size() - base);
        end
        for (int i = 0; i < 5 && base + i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[base+i] !== 16'h5000 + 16'(i) || wd_q[base+i] !== 8'h3C) begin
                n_fail++; $display("FAIL busy_start_write%0d: got %h<=%h expected %h<=3c", i, wa_q[base+i], wd_q[base+i], 16'h5000 + 16'(i));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_copy();
        int base; int ndone;
        base = wa_q.size();
        do_start(MODE_COPY, DIR_UP, 16'h2000, 16'h6000, 16'd8, 8'h00);
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h6000) begin
            n_fail++; $display("FAIL rst_mid_pre: we %b addr %h expected 1 6000", mem_we, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_immediate: we %b busy %b done %b expected 0 0 0", mem_we, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0 || wa_q.size() !== base) begin
            n_fail++; $display("FAIL rst_mid_after: done/busy cycles %0d writes %0d expected 0 0", ndone, wa_q.size() - base);
        end
    endtask

`ifdef BRAM_DMA_CHECKSUM_EN
    task automatic test_checksum();
        int nb; bit ok;
        do_start(MODE_FILL, DIR_UP, 16'h0000, 16'h7000, 16'd3, 8'h80);
        wait_done(nb, ok);
        n_checks++;
        if (!ok || csum !== 8'h80) begin
            n_fail++; $display("FAIL checksum: ok %b csum %h expected 1 80", ok, csum);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_copy_up();
        test_copy_down_wrap();
        test_abort();
        test_len_zero_and_busy_start();
        test_reset_mid_copy();
`ifdef BRAM_DMA_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
